// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   SEG_BLANK : segment bus value with every segment off (active-low bus)
//   AN_OFF    : level of one inactive anode enable (active-low anodes)
//   state_t   : per-slot scan phase (BLANK = anti-ghosting gap, DRIVE = digit lit)
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       AN_OFF    = 1'b1;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  // Span the slot counter must cover; never below 2 so the counter is >= 1 bit.
  function automatic int cnt_span(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m > 2) ? m : 2;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the result datapath and the display pins.
//   digit_data : nibble d at [4d+3:4d], digit 0 rightmost
//   digit_en   : per-digit lit enable (dark digits still consume their slot)
//   load       : one-cycle strobe capturing digit_data/digit_en
//   an         : anode enables, active-low
//   seg        : {g,f,e,d,c,b,a}, active-low
//   frame_done : pulse on the last DRIVE cycle of the last digit
// master = data source / pin observer, slave = scan controller.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    frame_done;

  modport master (
    output digit_data, digit_en, load,
    input  an, seg, frame_done
  );

  modport slave (
    input  digit_data, digit_en, load,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   hex : 4-bit value 0..F
//   seg : segment pattern, 0 = segment lit
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared
// hex decoder. Each slot is BLANK_CYC all-off cycles followed by DWELL_CYC
// cycles driving one digit. Incoming digits are double-buffered: a load lands
// in a shadow copy and is promoted to the displayed copy only at a frame
// boundary, so a frame never mixes old and new values.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_if slave (digit_data, digit_en, load in; an, seg, frame_done out)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_CYC  = 100000,
  parameter int BLANK_CYC  = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(cnt_span(DWELL_CYC, BLANK_CYC));
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // With no blanking gap every slot starts directly in DRIVE.
  localparam state_t           ST_START   = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shd_data, act_data;
  logic [NUM_DIGITS-1:0]   shd_en, act_en;
  logic                    pending;

  logic [3:0]              nib;
  logic                    lit;
  logic [6:0]              dec;

  logic [NUM_DIGITS-1:0]   an_p0, an_p1;
  logic [6:0]              seg_p0, seg_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_START;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    frame_end = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = ST_DRIVE;
          cnt_nx   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DWELL_LAST) begin
          cnt_nx    = '0;
          idx_nx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          state_nx  = ST_START;
          frame_end = (idx == IDX_LAST);
        end
      end
      default: state_nx = ST_START;
    endcase
  end

  // A load coinciding with the frame boundary bypasses the shadow hand-off
  // and goes straight to the displayed copy, leaving nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data <= '0;
      shd_en   <= '1;
      act_data <= '0;
      act_en   <= '1;
      pending  <= 1'b0;
    end else if (bus.load) begin
      shd_data <= bus.digit_data;
      shd_en   <= bus.digit_en;
      if (frame_end) begin
        act_data <= bus.digit_data;
        act_en   <= bus.digit_en;
        pending  <= 1'b0;
      end else begin
        pending  <= 1'b1;
      end
    end else if (frame_end && pending) begin
      act_data <= shd_data;
      act_en   <= shd_en;
      pending  <= 1'b0;
    end
  end

  always_comb begin
    nib = 4'h0;
    lit = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == IDX_W'(d)) begin
        nib = act_data[4*d +: 4];
        lit = act_en[d];
      end
    end
  end

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (dec)
  );

  // p0: pin values implied by the current slot position.
  always_comb begin
    an_p0  = {NUM_DIGITS{AN_OFF}};
    seg_p0 = SEG_BLANK;
    if (state == ST_DRIVE && lit) begin
      seg_p0 = dec;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (idx == IDX_W'(d)) an_p0[d] = ~AN_OFF;
      end
    end
  end

  // p1: registered pins; reset forces every anode off without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= {NUM_DIGITS{AN_OFF}};
      seg_p1 <= SEG_BLANK;
    end else begin
      an_p1  <= an_p0;
      seg_p1 <= seg_p0;
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYC=4,
// BLANK_CYC=1 (slot 5 cycles, frame 20 cycles).
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk;
  logic rst_n;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DWELL_CYC  (DWELL),
    .BLANK_CYC  (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: position in the frame follows from a plain cycle count.
  int          k;
  int          last_fd;
  logic [15:0] m_act_d, m_shd_d;
  logic [3:0]  m_act_e, m_shd_e;
  logic        m_pend;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
    logic [15:0] an_x;   // slot s expected anodes at [4s+3:4s]
    logic [27:0] seg_x;  // slot s expected segments at [7s+6:7s]
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    last_fd = -1;
    m_act_d = '0;
    m_shd_d = '0;
    m_act_e = 4'hF;
    m_shd_e = 4'hF;
    m_pend  = 1'b0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] e);
    int pos, slot, ph;
    logic [3:0] ea;
    logic [6:0] es;
    bus.load       = ld;
    bus.digit_data = d;
    bus.digit_en   = e;
    @(posedge clk);
    pos  = k % FRAME;
    slot = pos / SLOT;
    ph   = pos % SLOT;
    ea   = 4'hF;
    es   = 7'h7F;
    if (ph >= BLANK && m_act_e[slot]) begin
      ea[slot] = 1'b0;
      es       = DEC[m_act_d[4*slot +: 4]];
    end
    if (ld) begin
      m_shd_d = d;
      m_shd_e = e;
      m_pend  = 1'b1;
    end
    if (pos == FRAME - 1 && m_pend) begin
      m_act_d = m_shd_d;
      m_act_e = m_shd_e;
      m_pend  = 1'b0;
    end
    k++;
    @(negedge clk);
    bus.load = 1'b0;
    chk("an", 32'(bus.an), 32'(ea));
    chk("seg", 32'(bus.seg), 32'(es));
    chk("frame_done", 32'(bus.frame_done), 32'((k % FRAME) == FRAME - 1));
    if (bus.frame_done) begin
      if (last_fd >= 0) chk("frame_period", 32'(k - last_fd), 32'(FRAME));
      last_fd = k;
    end
  endtask

  task automatic run_to(input int m);
    for (int i = 0; i < FRAME && (k % FRAME) != m; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.load       = 1'b0;
    bus.digit_data = '0;
    bus.digit_en   = '0;
    model_reset();

    tbl[0] = '{16'h1234, 4'hF, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{16'h1234, 4'h5, 16'hFBFE, {7'h7F, 7'h24, 7'h7F, 7'h19}};
    tbl[2] = '{16'hABCD, 4'hF, 16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21}};
    tbl[3] = '{16'h8E6F, 4'hF, 16'h7BDE, {7'h00, 7'h06, 7'h02, 7'h0E}};
    tbl[4] = '{16'h0000, 4'h0, 16'hFFFF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    tbl[5] = '{16'h5A7C, 4'hA, 16'h7FDF, {7'h12, 7'h7F, 7'h78, 7'h7F}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // First slot after release: one blank cycle then digit 0 showing 0
    step(1'b0, 16'h0, 4'h0);
    chk("t1_blank_an", 32'(bus.an), 32'hF);
    for (int i = 0; i < DWELL; i++) begin
      step(1'b0, 16'h0, 4'h0);
      chk("t1_drive_an", 32'(bus.an), 32'hE);
      chk("t1_drive_seg", 32'(bus.seg), 32'h40);
    end

    // Table: mid-frame load, then check every drive cycle of the next frame
    for (int r = 0; r < 6; r++) begin
      run_to(7);
      step(1'b1, tbl[r].data, tbl[r].en);
      run_to(0);
      for (int s = 0; s < FRAME; s++) begin
        step(1'b0, 16'h0, 4'h0);
        if ((s % SLOT) >= BLANK) begin
          chk("tbl_an", 32'(bus.an), 32'(tbl[r].an_x[4*(s/SLOT) +: 4]));
          chk("tbl_seg", 32'(bus.seg), 32'(tbl[r].seg_x[7*(s/SLOT) +: 7]));
        end
      end
    end

    // Load exactly on the frame_done cycle goes straight to the next digit 0
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        if (bus.frame_done) begin
          seen = 1'b1;
          break;
        end
        step(1'b0, 16'h0, 4'h0);
      end
      chk("t4_frame_done_seen", 32'(seen), 32'h1);
      step(1'b1, 16'hABCD, 4'hF);
      step(1'b0, 16'h0, 4'h0);
      step(1'b0, 16'h0, 4'h0);
      chk("t4_an", 32'(bus.an), 32'hE);
      chk("t4_seg", 32'(bus.seg), 32'h21);
    end

    // Two loads in one frame: the last one wins
    run_to(3);
    step(1'b1, 16'h1111, 4'hF);
    run_to(12);
    step(1'b1, 16'h9999, 4'hF);
    run_to(0);
    for (int s = 0; s < FRAME; s++) begin
      step(1'b0, 16'h0, 4'h0);
      if ((s % SLOT) >= BLANK) chk("t5_seg", 32'(bus.seg), 32'h10);
    end

    // Reset during digit 2 drive: anodes drop off without a clock edge
    run_to(13);
    chk("t6_pre_an", 32'(bus.an), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_an", 32'(bus.an), 32'hF);
    chk("t6_async_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 16'h0, 4'h0);
    chk("t6_blank_an", 32'(bus.an), 32'hF);
    step(1'b0, 16'h0, 4'h0);
    chk("t6_an", 32'(bus.an), 32'hE);
    chk("t6_seg", 32'(bus.seg), 32'h40);

    // Randomized loads, including bursts held high, against the model
    begin
      int burst;
      burst = 0;
      for (int i = 0; i < 800; i++) begin
        if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 3);
        if (burst > 0) begin
          burst--;
          step(1'b1, 16'($urandom), 4'($urandom));
        end else begin
          step(1'b0, 16'($urandom), 4'($urandom));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
